// File: rtl/apb_rmw_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : apb_rmw_pkg
//  Description : Shared types and op codes for the APB read-modify-write
//                master: FSM state enum, command op codes and the RMW phase
//                enum, plus a small op-decode helper.
//  Revision    : 1.0  initial release
// ============================================================================
package apb_rmw_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    // RMW commands run two APB transfers; this tracks which one is on the bus.
    typedef enum logic {
        RD = 1'b0,
        WR = 1'b1
    } phase_t;

    localparam logic [1:0] OP_READ    = 2'b00;
    localparam logic [1:0] OP_WRITE   = 2'b01;
    localparam logic [1:0] OP_RMW_ADD = 2'b10;
    localparam logic [1:0] OP_RMW_CLR = 2'b11;

    // Both RMW op codes have the MSB set.
    function automatic logic is_rmw(input logic [1:0] op);
        return op[1];
    endfunction

endpackage
`default_nettype wire

// File: rtl/apb_rmw_wdog.sv
`default_nettype none
// ============================================================================
//  Module      : apb_rmw_wdog
//  Description : ACCESS-phase watchdog. Counts consecutive enabled cycles and
//                flags expiry on the TIMEOUT_CYC-th one. Only compiled when
//                APB_RMW_TIMEOUT_EN is defined.
//  Ports       : clk, rst      clock / async active-high reset
//                i_clr         restart the count (held while the FSM is in SETUP)
//                i_en          count this cycle (ACCESS with pready low)
//                o_expired     this enabled cycle is the TIMEOUT_CYC-th in a row
//  Revision    : 1.0  initial release
// ============================================================================
`ifdef APB_RMW_TIMEOUT_EN
module apb_rmw_wdog #(
    parameter int TIMEOUT_CYC = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);

    localparam int c_CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(TIMEOUT_CYC - 1);

    logic [c_CNT_W-1:0] r_cnt;

    // Combinational so the FSM can leave ACCESS on the very cycle that
    // completes the run of stalled cycles.
    assign o_expired = i_en && (r_cnt == c_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en && !o_expired) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule
`endif
`default_nettype wire

// File: rtl/apb_rmw_master.sv
`default_nettype none
// ============================================================================
//  Module      : apb_rmw_master
//  Description : APB master executing single READ / WRITE commands and atomic
//                read-modify-write (add or clear-bits) commands from a simple
//                valid/ready command port. One-cycle response pulse.
//  Ports       : pclk, preset           clock / async active-high reset
//                cmd_valid/cmd_ready    command handshake
//                cmd_op/addr/data       op code, address, write data/operand
//                rsp_valid/data/err     completion pulse, read data, error
//                busy                   command in flight
//                psel..pwdata           APB request outputs
//                prdata/pready/pslverr  APB completion inputs
//  Config      : APB_RMW_TIMEOUT_EN  when defined, an ACCESS phase stalled for
//                TIMEOUT_CYC consecutive cycles is abandoned with rsp_err=1.
//  Revision    : 1.0  initial release
// ============================================================================
module apb_rmw_master
    import apb_rmw_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic              pclk,
    input  logic              preset,
    // command / response
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,
    output logic              busy,
    // APB
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pready,
    input  logic              pslverr
);

    state_t            r_state;
    phase_t            r_phase;
    logic [1:0]        r_op;
    logic [DATA_W-1:0] r_operand;

    logic [DATA_W-1:0] w_wdata_mod;
    logic              w_to_expired;

    assign cmd_ready = (r_state == IDLE);
    assign busy      = (r_state != IDLE);

    // Write-back value for the RMW write phase, built from the live read data
    // in the cycle the read completes. The add wraps (carry dropped).
    always_comb begin
        w_wdata_mod = prdata & ~r_operand;
        if (r_op == OP_RMW_ADD) begin
            w_wdata_mod = prdata + r_operand;
        end
    end

`ifdef APB_RMW_TIMEOUT_EN
    apb_rmw_wdog #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_wdog (
        .clk       (pclk),
        .rst       (preset),
        .i_clr     (r_state == SETUP),
        .i_en      ((r_state == ACCESS) && !pready),
        .o_expired (w_to_expired)
    );
`else
    // No watchdog in this build: ACCESS waits for pready indefinitely.
    // TIMEOUT_CYC is never negative, so this is constant false.
    assign w_to_expired = (TIMEOUT_CYC < 0);
`endif

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            r_state   <= IDLE;
            r_phase   <= RD;
            r_op      <= OP_READ;
            r_operand <= '0;
            psel      <= 1'b0;
            penable   <= 1'b0;
            pwrite    <= 1'b0;
            paddr     <= '0;
            pwdata    <= '0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_data  <= '0;
        end else begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;

            case (r_state)
                IDLE: begin
                    if (cmd_valid) begin
                        r_op      <= cmd_op;
                        r_operand <= cmd_data;
                        r_phase   <= RD;
                        psel      <= 1'b1;
                        penable   <= 1'b0;
                        paddr     <= cmd_addr;
                        pwrite    <= (cmd_op == OP_WRITE);
                        pwdata    <= (cmd_op == OP_WRITE) ? cmd_data : '0;
                        r_state   <= SETUP;
                    end
                end

                SETUP: begin
                    penable <= 1'b1;
                    r_state <= ACCESS;
                end

                ACCESS: begin
                    if (pready) begin
                        if (is_rmw(r_op) && (r_phase == RD) && !pslverr) begin
                            // Read half done: keep the pre-modify value for the
                            // response, then start the write-back transfer.
                            rsp_data <= prdata;
                            penable  <= 1'b0;
                            pwrite   <= 1'b1;
                            pwdata   <= w_wdata_mod;
                            r_phase  <= WR;
                            r_state  <= SETUP;
                        end else begin
                            r_state   <= IDLE;
                            psel      <= 1'b0;
                            penable   <= 1'b0;
                            pwrite    <= 1'b0;
                            paddr     <= '0;
                            pwdata    <= '0;
                            rsp_valid <= 1'b1;
                            rsp_err   <= pslverr;
                            // RMW write phase keeps the value captured on read.
                            if (r_op == OP_WRITE) begin
                                rsp_data <= '0;
                            end else if (r_phase == RD) begin
                                rsp_data <= prdata;
                            end
                        end
                    end else if (w_to_expired) begin
                        r_state   <= IDLE;
                        psel      <= 1'b0;
                        penable   <= 1'b0;
                        pwrite    <= 1'b0;
                        paddr     <= '0;
                        pwdata    <= '0;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                        rsp_data  <= '0;
                    end
                end

                default: begin
                    r_state <= IDLE;
                    psel    <= 1'b0;
                    penable <= 1'b0;
                    pwrite  <= 1'b0;
                    paddr   <= '0;
                    pwdata  <= '0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_apb_rmw_master.sv
`default_nettype none
// ============================================================================
//  Module      : tb_apb_rmw_master
//  Description : Self-checking bench for apb_rmw_master. A behavioural APB
//                slave with configurable wait states, read data and error
//                drives the bus; a table of commands with hand-computed
//                results is applied, followed by back-to-back, mid-op reset
//                and (with APB_RMW_TIMEOUT_EN) timeout sequences.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_apb_rmw_master;
    import apb_rmw_pkg::*;

    logic        pclk;
    logic        preset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_data;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic        busy;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;

    apb_rmw_master #(
        .ADDR_W      (32),
        .DATA_W      (32),
        .TIMEOUT_CYC (4)
    ) dut (
        .pclk      (pclk),
        .preset    (preset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_addr  (cmd_addr),
        .cmd_data  (cmd_data),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .busy      (busy),
        .psel      (psel),
        .penable   (penable),
        .pwrite    (pwrite),
        .paddr     (paddr),
        .pwdata    (pwdata),
        .prdata    (prdata),
        .pready    (pready),
        .pslverr   (pslverr)
    );

    initial begin
        pclk = 1'b0;
        forever #5 pclk = ~pclk;
    end

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural APB slave + bus monitor ----------------
    logic [31:0] s_rdata = 32'h0;
    int          s_waits = 0;
    bit          s_err   = 1'b0;
    int          s_wait_cnt = 0;

    int          n_wr = 0, n_setup = 0, n_pwh = 0;
    int          n_idle_viol = 0, n_stab_viol = 0;
    logic [31:0] last_wdata = 32'h0;
    logic [31:0] sv_addr, sv_wdata;
    logic        sv_write;

    initial begin
        pready  = 1'b0;
        pslverr = 1'b0;
        prdata  = 32'h0;
    end

    always @(negedge pclk) begin
        if (psel && !penable) begin
            n_setup++;
            sv_addr  = paddr;
            sv_wdata = pwdata;
            sv_write = pwrite;
        end
        if (psel && pwrite) n_pwh++;
        if (psel && penable) begin
            if (paddr !== sv_addr || pwdata !== sv_wdata || pwrite !== sv_write) n_stab_viol++;
            pready = (s_wait_cnt >= s_waits);
            if (pready) s_wait_cnt = 0;
            else        s_wait_cnt++;
            // Garbage on prdata except during a read ACCESS.
            prdata  = pwrite ? $urandom : s_rdata;
            pslverr = pready && s_err;
            if (pready && pwrite) begin
                n_wr++;
                last_wdata = pwdata;
            end
        end else begin
            pready     = 1'b0;
            pslverr    = 1'b0;
            s_wait_cnt = 0;
            prdata     = $urandom;
            if (!psel && (penable || pwrite || paddr != 0 || pwdata != 0)) n_idle_viol++;
        end
    end

    // Issue one command and wait for its response. lat counts clock edges
    // from the accepting edge (1) to the edge that raises rsp_valid; -1 if
    // no response arrived within the budget.
    task automatic run_cmd(input logic [1:0] op, input logic [31:0] addr, input logic [31:0] data,
                           output int lat, output logic [31:0] rdata, output logic err);
        @(negedge pclk);
        check("cmd_ready_idle", cmd_ready, 1'b1);
        n_wr = 0; n_setup = 0; n_pwh = 0;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_addr  = addr;
        cmd_data  = data;
        @(posedge pclk); #1;
        cmd_valid = 1'b0;
        cmd_op    = 2'($urandom);
        cmd_addr  = $urandom;
        cmd_data  = $urandom;
        lat = 1;
        while (!rsp_valid && lat < 100) begin
            @(posedge pclk); #1;
            lat++;
        end
        if (!rsp_valid) lat = -1;
        rdata = rsp_data;
        err   = rsp_err;
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] rdata;
        int          waits;
        bit          err;
        logic [31:0] exp_rsp;
        bit          exp_err;
        int          exp_lat;
        int          exp_nwr;
        logic [31:0] exp_wdata;
        int          exp_setup;
    } vec_t;

    vec_t vecs[8];

    int          lat;
    logic [31:0] rd;
    logic        er;
    bit          saw_rsp;

    initial begin
        vecs[0] = '{op:OP_READ,    addr:32'hA000, data:32'h0,        rdata:32'h1234,     waits:0, err:0,
                    exp_rsp:32'h1234,     exp_err:0, exp_lat:3, exp_nwr:0, exp_wdata:32'h0,        exp_setup:1};
        vecs[1] = '{op:OP_RMW_ADD, addr:32'hA000, data:32'h1,        rdata:32'hFFFF_FFFF, waits:0, err:0,
                    exp_rsp:32'hFFFF_FFFF, exp_err:0, exp_lat:5, exp_nwr:1, exp_wdata:32'h0,        exp_setup:2};
        vecs[2] = '{op:OP_RMW_CLR, addr:32'hA004, data:32'h0F,       rdata:32'hFF,       waits:2, err:0,
                    exp_rsp:32'hFF,       exp_err:0, exp_lat:9, exp_nwr:1, exp_wdata:32'hF0,       exp_setup:2};
        vecs[3] = '{op:OP_RMW_ADD, addr:32'hA008, data:32'h1,        rdata:32'h55,       waits:0, err:1,
                    exp_rsp:32'h55,       exp_err:1, exp_lat:3, exp_nwr:0, exp_wdata:32'h0,        exp_setup:1};
        vecs[4] = '{op:OP_WRITE,   addr:32'hA00C, data:32'hDEAD_BEEF, rdata:32'h7777,    waits:1, err:0,
                    exp_rsp:32'h0,        exp_err:0, exp_lat:4, exp_nwr:1, exp_wdata:32'hDEAD_BEEF, exp_setup:1};
        vecs[5] = '{op:OP_RMW_ADD, addr:32'hA010, data:32'h22,       rdata:32'h10,       waits:1, err:0,
                    exp_rsp:32'h10,       exp_err:0, exp_lat:7, exp_nwr:1, exp_wdata:32'h32,       exp_setup:2};
        vecs[6] = '{op:OP_READ,    addr:32'hA014, data:32'h0,        rdata:32'hCAFE,     waits:0, err:1,
                    exp_rsp:32'hCAFE,     exp_err:1, exp_lat:3, exp_nwr:0, exp_wdata:32'h0,        exp_setup:1};
        vecs[7] = '{op:OP_WRITE,   addr:32'hA018, data:32'h0BAD_0001, rdata:32'h0,       waits:0, err:1,
                    exp_rsp:32'h0,        exp_err:1, exp_lat:3, exp_nwr:1, exp_wdata:32'h0BAD_0001, exp_setup:1};

        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_addr  = 32'h0;
        cmd_data  = 32'h0;
        preset    = 1'b0;
        #2 preset = 1'b1;

        // ---------------- reset state ----------------
        @(negedge pclk);
        check("rst_psel",      psel,      1'b0);
        check("rst_penable",   penable,   1'b0);
        check("rst_pwrite",    pwrite,    1'b0);
        check("rst_paddr",     paddr,     32'h0);
        check("rst_pwdata",    pwdata,    32'h0);
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_rsp_err",   rsp_err,   1'b0);
        check("rst_rsp_data",  rsp_data,  32'h0);
        check("rst_cmd_ready", cmd_ready, 1'b1);
        check("rst_busy",      busy,      1'b0);
        @(negedge pclk);
        preset = 1'b0;

        // ---------------- table-driven commands ----------------
        for (int i = 0; i < 8; i++) begin
            s_rdata = vecs[i].rdata;
            s_waits = vecs[i].waits;
            s_err   = vecs[i].err;
            run_cmd(vecs[i].op, vecs[i].addr, vecs[i].data, lat, rd, er);
            check($sformatf("v%0d_lat", i),       lat,        vecs[i].exp_lat);
            check($sformatf("v%0d_rsp_data", i),  rd,         vecs[i].exp_rsp);
            check($sformatf("v%0d_rsp_err", i),   er,         vecs[i].exp_err);
            check($sformatf("v%0d_n_write", i),   n_wr,       vecs[i].exp_nwr);
            check($sformatf("v%0d_n_setup", i),   n_setup,    vecs[i].exp_setup);
            check($sformatf("v%0d_pwrite_seen", i), (n_pwh != 0), (vecs[i].exp_nwr != 0));
            if (vecs[i].exp_nwr != 0)
                check($sformatf("v%0d_pwdata", i), last_wdata, vecs[i].exp_wdata);
            @(posedge pclk); #1;
            check($sformatf("v%0d_rsp_pulse", i), rsp_valid, 1'b0);
        end
        s_err = 1'b0;

        // ---------------- back-to-back WRITE then READ ----------------
        s_rdata = 32'h0BAD_F00D;
        s_waits = 0;
        n_wr = 0;
        @(negedge pclk);
        cmd_valid = 1'b1;
        cmd_op    = OP_WRITE;
        cmd_addr  = 32'hB000;
        cmd_data  = 32'h1111_2222;
        @(posedge pclk); #1;
        cmd_op    = OP_READ;
        cmd_addr  = 32'hB004;
        cmd_data  = 32'h0;
        @(posedge pclk); #1;
        @(posedge pclk); #1;
        check("b2b_wr_rsp_valid", rsp_valid, 1'b1);
        check("b2b_wr_rsp_data",  rsp_data,  32'h0);
        check("b2b_cmd_ready",    cmd_ready, 1'b1);
        check("b2b_wr_pwdata",    last_wdata, 32'h1111_2222);
        @(posedge pclk); #1;
        cmd_valid = 1'b0;
        check("b2b_rd_busy",   busy,    1'b1);
        check("b2b_rd_psel",   psel,    1'b1);
        check("b2b_rd_pwrite", pwrite,  1'b0);
        check("b2b_rd_paddr",  paddr,   32'hB004);
        @(posedge pclk); #1;
        @(posedge pclk); #1;
        check("b2b_rd_rsp_valid", rsp_valid, 1'b1);
        check("b2b_rd_rsp_data",  rsp_data,  32'h0BAD_F00D);
        check("b2b_n_write",      n_wr,      1);

        // ---------------- reset in the middle of an RMW ----------------
        s_waits = 3;
        n_wr = 0;
        @(negedge pclk);
        cmd_valid = 1'b1;
        cmd_op    = OP_RMW_ADD;
        cmd_addr  = 32'hC000;
        cmd_data  = 32'h5;
        @(posedge pclk); #1;
        cmd_valid = 1'b0;
        @(posedge pclk); #1;
        check("mid_access_penable", penable, 1'b1);
        preset = 1'b1;
        #1;
        check("mid_rst_psel",    psel,      1'b0);
        check("mid_rst_penable", penable,   1'b0);
        check("mid_rst_pwrite",  pwrite,    1'b0);
        check("mid_rst_paddr",   paddr,     32'h0);
        check("mid_rst_pwdata",  pwdata,    32'h0);
        check("mid_rst_busy",    busy,      1'b0);
        check("mid_rst_ready",   cmd_ready, 1'b1);
        @(negedge pclk);
        preset = 1'b0;
        saw_rsp = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(posedge pclk); #1;
            if (rsp_valid) saw_rsp = 1'b1;
        end
        check("mid_rst_no_rsp",  saw_rsp, 1'b0);
        check("mid_rst_no_wr",   n_wr,    0);

        // recovery after reset
        s_waits = 0;
        s_rdata = 32'h600D;
        run_cmd(OP_READ, 32'hC004, 32'h0, lat, rd, er);
        check("recover_lat",  lat, 3);
        check("recover_data", rd,  32'h600D);

`ifdef APB_RMW_TIMEOUT_EN
        // ---------------- ACCESS timeout ----------------
        s_waits = 1000;
        s_rdata = 32'h1234_5678;
        run_cmd(OP_RMW_ADD, 32'hD000, 32'h1, lat, rd, er);
        check("to_lat",      lat,  6);
        check("to_rsp_err",  er,   1'b1);
        check("to_rsp_data", rd,   32'h0);
        check("to_psel",     psel, 1'b0);
        check("to_n_write",  n_wr, 0);
        s_waits = 0;
`endif

        // ---------------- global bus rules ----------------
        check("idle_bus_zero",     n_idle_viol, 0);
        check("setup_access_stab", n_stab_viol, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    // Absolute time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "time limit");
    end

endmodule
`default_nettype wire
